// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary encoder controller: register map,
// CTRL field positions, reset values and the position update rule.
package rotary_pkg;

  typedef enum logic [1:0] {
    REG_CTRL     = 2'd0,
    REG_POSITION = 2'd1,
    REG_LIMIT    = 2'd2,
    REG_EVENT    = 2'd3
  } reg_addr_t;

  // Writable CTRL fields (the queue count and overflow flag are read-only views).
  typedef struct packed {
    logic [3:0] step;
    logic       irq_en;
    logic       wrap;
    logic       enable;
  } ctrl_t;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_WRAP_BIT   = 1;
  localparam int CTRL_IRQ_BIT    = 2;
  localparam int CTRL_STEP_LSB   = 4;
  localparam int CTRL_STEP_MSB   = 7;
  localparam int CTRL_COUNT_LSB  = 8;
  localparam int CTRL_COUNT_MSB  = 12;
  localparam int CTRL_OVF_BIT    = 13;

  localparam ctrl_t       CTRL_RESET     = '{step: 4'd1, irq_en: 1'b0, wrap: 1'b0, enable: 1'b0};
  localparam logic [15:0] POSITION_RESET = 16'h0000;
  localparam logic [15:0] LIMIT_RESET    = 16'hFFFF;
  localparam logic [1:0]  SYNC_RESET     = 2'b11;

  // New POSITION after one detent. A step of 0 moves by 1. Right moves use
  // 17-bit arithmetic so a carry out of bit 15 still counts as "above LIMIT".
  function automatic logic [15:0] next_position(input logic [15:0] pos,
                                                input logic [15:0] limit,
                                                input logic [3:0]  step,
                                                input logic        right,
                                                input logic        wrap);
    logic [15:0] s;
    logic [16:0] sum;
    logic [15:0] result;
    s   = (step == 4'd0) ? 16'd1 : {12'd0, step};
    sum = {1'b0, pos} + {1'b0, s};
    if (right) begin
      if (sum > {1'b0, limit}) result = wrap ? 16'd0 : limit;
      else                     result = sum[15:0];
    end else begin
      if (pos < s) result = wrap ? limit : 16'd0;
      else         result = pos - s;
    end
    return result;
  endfunction

endpackage

// File: rtl/rotary_quadrature.sv
// Synchronizer and detent decoder for a two-phase rotary encoder.
// Ports:
//   clock, reset_n  - system clock, synchronous active-low reset
//   rotary_in[1:0]  - raw asynchronous encoder inputs {A, B}
//   step_event      - one-cycle pulse per detent (registered rising edge of q1)
//   step_right      - direction of that detent, 1 = right
// q1 only changes on 00/11 and q2 only on 01/10, so contact bounce on one
// phase while the other is stable cannot produce more than one event.
module rotary_quadrature
  import rotary_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] rotary_in,
  output logic       step_event,
  output logic       step_right
);

  logic [1:0] sync1;
  logic [1:0] sync2;
  logic       q1;
  logic       q1_d;
  logic       q2;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1      <= SYNC_RESET;
      sync2      <= SYNC_RESET;
      q1         <= 1'b1;
      q1_d       <= 1'b1;
      q2         <= 1'b0;
      step_event <= 1'b0;
      step_right <= 1'b0;
    end else begin
      sync1 <= rotary_in;
      sync2 <= sync1;
      if (sync2 == 2'b00) q1 <= 1'b0;
      else if (sync2 == 2'b11) q1 <= 1'b1;
      if (sync2 == 2'b01) q2 <= 1'b0;
      else if (sync2 == 2'b10) q2 <= 1'b1;
      q1_d       <= q1;
      step_event <= q1 & ~q1_d;
      step_right <= q2;
    end
  end

endmodule

// File: rtl/rotary_controller.sv
// Rotary encoder controller with a CPU register port and a direction queue.
// Ports:
//   clock, reset_n        - system clock, synchronous active-low reset
//   rotary_in[1:0]        - raw encoder {A, B}
//   address[1:0]          - register select (CTRL, POSITION, LIMIT, EVENT)
//   data_in[31:0]         - write data
//   write, read           - one-cycle access strobes
//   ack                   - access complete
//   data_out[31:0]        - read data, valid while ack=1
//   interrupt             - level interrupt request
// Access handshake: a strobe sampled high on a rising edge is serviced on
// that edge and ack is high for exactly the following cycle; read data is
// presented alongside ack. A strobe with both read and write set is a write.
module rotary_controller
  import rotary_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  rotary_in,
  input  logic [1:0]  address,
  input  logic [31:0] data_in,
  input  logic        write,
  input  logic        read,
  output logic        ack,
  output logic [31:0] data_out,
  output logic        interrupt
);

  localparam int          PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  DEPTH_COUNT = 5'(FIFO_DEPTH);

  logic             step_event;
  logic             step_right;
  ctrl_t            ctrl;
  logic [15:0]      position;
  logic [15:0]      limit;
  logic             overflow;
  logic             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [4:0]       count;

  reg_addr_t   addr;
  logic        read_en;
  logic        push;
  logic        pop;
  logic        push_ok;
  logic        drop;
  logic        fifo_empty;
  logic        fifo_full;
  logic [15:0] event_position;
  logic [15:0] write_position;
  logic [31:0] rdata;
  logic        unused_data;

  rotary_quadrature u_quadrature (
    .clock      (clock),
    .reset_n    (reset_n),
    .rotary_in  (rotary_in),
    .step_event (step_event),
    .step_right (step_right)
  );

  assign unused_data = ^{data_in[31:16], data_in[12:8], data_in[3]};

  always_comb begin
    addr           = reg_addr_t'(address);
    read_en        = read & ~write;
    fifo_empty     = (count == 5'd0);
    fifo_full      = (count == DEPTH_COUNT);
    push           = step_event & ctrl.enable;
    pop            = read_en & (addr == REG_EVENT) & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    push_ok        = push & (~fifo_full | pop);
    drop           = push & fifo_full & ~pop;
    event_position = next_position(position, limit, ctrl.step, step_right, ctrl.wrap);
    write_position = (data_in[15:0] > limit) ? limit : data_in[15:0];

    rdata = '0;
    case (addr)
      REG_CTRL: begin
        rdata[CTRL_ENABLE_BIT]               = ctrl.enable;
        rdata[CTRL_WRAP_BIT]                 = ctrl.wrap;
        rdata[CTRL_IRQ_BIT]                  = ctrl.irq_en;
        rdata[CTRL_STEP_MSB:CTRL_STEP_LSB]   = ctrl.step;
        rdata[CTRL_COUNT_MSB:CTRL_COUNT_LSB] = count;
        rdata[CTRL_OVF_BIT]                  = overflow;
      end
      REG_POSITION: rdata[15:0] = position;
      REG_LIMIT:    rdata[15:0] = limit;
      REG_EVENT:    if (!fifo_empty) rdata = {1'b1, 30'd0, fifo_mem[rd_ptr]};
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem[wr_ptr] <= step_right;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ctrl      <= CTRL_RESET;
      position  <= POSITION_RESET;
      limit     <= LIMIT_RESET;
      overflow  <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= 5'd0;
      ack       <= 1'b0;
      data_out  <= 32'd0;
      interrupt <= 1'b0;
    end else begin
      ack      <= write | read;
      data_out <= read_en ? rdata : 32'd0;

      if (write && addr == REG_CTRL) begin
        ctrl <= '{step:   data_in[CTRL_STEP_MSB:CTRL_STEP_LSB],
                  irq_en: data_in[CTRL_IRQ_BIT],
                  wrap:   data_in[CTRL_WRAP_BIT],
                  enable: data_in[CTRL_ENABLE_BIT]};
      end
      if (write && addr == REG_LIMIT) limit <= data_in[15:0];

      // A CPU write beats a same-cycle detent; a lowered LIMIT pulls
      // POSITION down on the edge after it is written.
      if (write && addr == REG_POSITION) position <= write_position;
      else if (push)                     position <= event_position;
      else if (position > limit)         position <= limit;

      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)      count <= count + 5'd1;
      else if (pop && !push_ok) count <= count - 5'd1;

      if (drop) overflow <= 1'b1;
      else if (write && addr == REG_CTRL && data_in[CTRL_OVF_BIT]) overflow <= 1'b0;

      interrupt <= ctrl.irq_en & (~fifo_empty | overflow);
    end
  end

endmodule

// File: tb/tb_rotary_controller.sv
// Testbench for rotary_controller: directed scenarios plus randomized
// traffic, checked against an arithmetic reference model.
module tb_rotary_controller;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  rotary_in;
  logic [1:0]  address;
  logic [31:0] data_in;
  logic        write;
  logic        read;
  logic        ack;
  logic [31:0] data_out;
  logic        interrupt;

  int checks   = 0;
  int failures = 0;

  // bit 32: entry is a read whose data must be compared
  logic [32:0] exp_q[$];

  // Reference model state
  int m_pos;
  int m_limit;
  int m_step;
  bit m_en;
  bit m_wrap;
  bit m_irq;
  bit m_ovf;
  bit m_q[$];

  rotary_controller #(.FIFO_DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rotary_in (rotary_in),
    .address   (address),
    .data_in   (data_in),
    .write     (write),
    .read      (read),
    .ack       (ack),
    .data_out  (data_out),
    .interrupt (interrupt)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic void model_reset();
    m_pos = 0; m_limit = 65535; m_step = 1;
    m_en = 0; m_wrap = 0; m_irq = 0; m_ovf = 0;
    m_q.delete();
  endfunction

  function automatic void model_event(input bit right);
    int s;
    if (!m_en) return;
    s = (m_step == 0) ? 1 : m_step;
    if (right) begin
      if (m_pos + s > m_limit) m_pos = m_wrap ? 0 : m_limit;
      else                     m_pos = m_pos + s;
    end else begin
      if (m_pos < s) m_pos = m_wrap ? m_limit : 0;
      else           m_pos = m_pos - s;
    end
    if (m_q.size() < DEPTH) m_q.push_back(right);
    else                    m_ovf = 1;
  endfunction

  function automatic logic [31:0] model_access(input bit is_write, input logic [1:0] addr,
                                               input logic [31:0] d);
    int dv;
    bit r;
    dv = int'(d[15:0]);
    if (is_write) begin
      case (addr)
        2'd0: begin
          m_en = d[0]; m_wrap = d[1]; m_irq = d[2]; m_step = int'(d[7:4]);
          if (d[13]) m_ovf = 0;
        end
        2'd1: m_pos = (dv > m_limit) ? m_limit : dv;
        2'd2: begin
          m_limit = dv;
          if (m_pos > m_limit) m_pos = m_limit;
        end
        default: ;
      endcase
      return 32'd0;
    end
    case (addr)
      2'd0: return {18'd0, m_ovf, 5'(m_q.size()), 4'(m_step), 1'b0, m_irq, m_wrap, m_en};
      2'd1: return {16'd0, 16'(m_pos)};
      2'd2: return {16'd0, 16'(m_limit)};
      default: begin
        if (m_q.size() == 0) return 32'd0;
        r = m_q.pop_front();
        return {1'b1, 30'd0, r};
      end
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic reg_access(input bit is_write, input bit also_read, input logic [1:0] addr,
                            input logic [31:0] d);
    logic [31:0] e;
    @(negedge clock);
    e = model_access(is_write, addr, d);
    exp_q.push_back({~is_write, e});
    address = addr;
    data_in = d;
    write   = is_write;
    read    = ~is_write | also_read;
    @(negedge clock);
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] d);
    reg_access(1'b1, 1'b0, addr, d);
  endtask

  task automatic rd(input logic [1:0] addr);
    reg_access(1'b0, 1'b0, addr, 32'd0);
  endtask

  task automatic detent(input bit right, input int hold);
    logic [1:0] seq [4];
    if (right) seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    else       seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      rotary_in = seq[i];
      repeat (hold - 1) @(negedge clock);
    end
    repeat (6) @(negedge clock);
    model_event(right);
  endtask

  // The access strobe lands on the same edge that applies the detent
  // (fifth rising edge after the input reaches 11).
  task automatic detent_with_access(input bit right, input bit event_first, input bit is_write,
                                    input logic [1:0] addr, input logic [31:0] d);
    @(negedge clock);
    rotary_in = right ? 2'b10 : 2'b01;
    repeat (2) @(negedge clock);
    @(negedge clock);
    rotary_in = 2'b11;
    repeat (3) @(negedge clock);
    if (event_first) model_event(right);
    reg_access(is_write, 1'b0, addr, d);
    if (!event_first) model_event(right);
    @(negedge clock);
    rotary_in = right ? 2'b01 : 2'b10;
    repeat (2) @(negedge clock);
    @(negedge clock);
    rotary_in = 2'b00;
    repeat (6) @(negedge clock);
  endtask

  // Phase A chatters while B stays high: one left detent at most.
  task automatic bounce(input int toggles);
    @(negedge clock);
    rotary_in = 2'b01;
    repeat (2) @(negedge clock);
    for (int i = 0; i < toggles; i++) begin
      @(negedge clock);
      rotary_in = (i % 2 == 0) ? 2'b11 : 2'b01;
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    @(negedge clock);
    rotary_in = 2'b00;
    repeat (6) @(negedge clock);
    model_event(1'b0);
  endtask

  task automatic check_irq(input string name);
    bit e;
    repeat (2) @(negedge clock);
    e = m_irq & ((m_q.size() != 0) | m_ovf);
    checks++;
    if (interrupt !== e) begin
      failures++;
      $display("FAIL irq_%s: interrupt=%b expected %b", name, interrupt, e);
    end
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset_n = 1'b0; read = 1'b0; write = 1'b0; rotary_in = 2'b00;
    repeat (2) @(negedge clock);
    checks += 3;
    if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack: ack=%b expected 0", ack); end
    if (data_out !== 32'd0) begin failures++; $display("FAIL reset_data: data_out=%h expected 0", data_out); end
    if (interrupt !== 1'b0) begin failures++; $display("FAIL reset_irq: interrupt=%b expected 0", interrupt); end
    reset_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clock);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    bit          strobe_q;
    logic [32:0] e;
    forever begin
      @(posedge clock);
      strobe_q = reset_n && (read || write);
      @(negedge clock);
      if (ack !== 1'b0 || strobe_q) begin
        checks++;
        if (ack !== strobe_q) begin
          failures++;
          $display("FAIL ack_timing: ack=%b expected %b at %0t", ack, strobe_q, $time);
        end
      end
      if (ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ack: no access outstanding at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          if (e[32]) begin
            checks++;
            if (data_out !== e[31:0]) begin
              failures++;
              $display("FAIL read_data: data_out=%h expected %h at %0t", data_out, e[31:0], $time);
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    int          op;
    reset_n = 1'b0; rotary_in = 2'b00; address = 2'd0; data_in = 32'd0;
    write = 1'b0; read = 1'b0;
    reset_dut();

    // Reset register values
    rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);
    check_irq("reset");

    // Single right detent with irq disabled
    wr(2'd0, 32'h11);
    detent(1'b1, 3);
    rd(2'd1); rd(2'd0);
    check_irq("single");

    // Saturate / wrap at LIMIT
    wr(2'd2, 32'd9); wr(2'd1, 32'd8); wr(2'd0, 32'h31);
    detent(1'b1, 3); rd(2'd1);
    wr(2'd0, 32'h33); wr(2'd1, 32'd8);
    detent(1'b1, 2); rd(2'd1);
    wr(2'd1, 32'd1);
    detent(1'b0, 2); rd(2'd1);

    // Queue overflow, draining, sticky overflow and interrupt
    reset_dut();
    wr(2'd0, 32'h15);
    repeat (5) detent(1'b1, 2);
    rd(2'd0);
    check_irq("overflow");
    repeat (5) rd(2'd3);
    check_irq("sticky");
    wr(2'd0, 32'h2015);
    check_irq("cleared");
    rd(2'd0);

    // Pop and push on a full queue in the same cycle
    reset_dut();
    wr(2'd0, 32'h11);
    repeat (4) detent(1'b0, 2);
    detent_with_access(1'b1, 1'b0, 1'b0, 2'd3, 32'd0);
    rd(2'd0);
    repeat (4) rd(2'd3);

    // POSITION write collides with a left detent
    reset_dut();
    wr(2'd0, 32'h11);
    detent_with_access(1'b0, 1'b1, 1'b1, 2'd1, 32'h1234);
    rd(2'd1); rd(2'd3);

    // Lowering LIMIT clamps POSITION; later writes are clamped too
    wr(2'd1, 32'd500); wr(2'd2, 32'd100); rd(2'd1);
    wr(2'd1, 32'd200); rd(2'd1);

    // Read and write together act as a write only
    reg_access(1'b1, 1'b1, 2'd1, 32'd7); rd(2'd1);
    detent(1'b1, 2);
    reg_access(1'b1, 1'b1, 2'd3, 32'd0); rd(2'd0);

    // Bounce, then the same with the controller disabled
    wr(2'd0, 32'h11); rd(2'd1);
    bounce(10); rd(2'd1); rd(2'd0);
    wr(2'd0, 32'h10);
    bounce(10); detent(1'b1, 2); rd(2'd1); rd(2'd0);

    // Reset on the same edge as a read strobe: no ack follows
    @(negedge clock);
    address = 2'd1; read = 1'b1; reset_n = 1'b0;
    @(negedge clock);
    read = 1'b0;
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL reset_mid_access: ack=%b expected 0", ack); end
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clock);
    rd(2'd1);

    // Randomized traffic
    reset_dut();
    wr(2'd2, 32'd30);
    wr(2'd0, 32'h15);
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: detent(1'($urandom_range(0, 1)), $urandom_range(1, 4));
        4: begin
          d = $urandom_range(0, 32'h3FFF);
          if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
          wr(2'd0, d);
        end
        5: begin
          d = $urandom_range(0, 40);
          if ($urandom_range(0, 1) == 1) d = d | 32'hABCD0000;
          wr(2'd2, d);
        end
        6: wr(2'd1, $urandom_range(0, 60));
        default: rd(2'($urandom_range(0, 3)));
      endcase
      if (n % 3 == 0) check_irq("random");
    end
    rd(2'd0); rd(2'd1); rd(2'd2);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_acks: outstanding=%0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rotary_controller.md
ROTARY_CONTROLLER -- requirements
Module: rotary_controller

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, power-of-two event-queue depth (2..16).
REQ-002 SHALL have port clock  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port rotary_in  input  2  raw asynchronous encoder A:B.
REQ-005 SHALL have port address  input  2  register select.
REQ-006 SHALL have port data_in  input  32  write data.
REQ-007 SHALL have port write  input  1  write strobe, one cycle.
REQ-008 SHALL have port read  input  1  read strobe, one cycle.
REQ-009 SHALL have port ack  output  1  access complete.
REQ-010 SHALL have port data_out  output  32  read data, valid while ack=1.
REQ-011 SHALL have port interrupt  output  1  level request to CPU.

Function
REQ-012 SHALL pass rotary_in through a 2-flop synchronizer, then a decoder: q1 cleared on 00, set on 11, held otherwise; q2 cleared on 01, set on 10, held otherwise; event = registered rising edge of q1; direction right = q2.
REQ-013 SHALL apply a decoded event to POSITION and queue on the 5th rising edge after rotary_in settles at 11.
REQ-014 SHALL decode registers: 0 CTRL, 1 POSITION[15:0], 2 LIMIT[15:0], 3 EVENT; unused read bits return 0.
REQ-015 CTRL bits: [0] enable, [1] wrap mode, [2] irq enable, [7:4] step (0 treated as 1); read adds [12:8] queue count, [13] overflow sticky.
REQ-016 SHALL assert ack exactly one cycle after each read or write strobe; read and write together in one cycle SHALL be treated as a write only.
REQ-017 Right event: POSITION+step in 17-bit arithmetic; result > LIMIT gives LIMIT (saturate) or 0 (wrap).
REQ-018 Left event: POSITION < step gives 0 (saturate) or LIMIT (wrap); else POSITION-step.
REQ-019 With enable=0, events SHALL be discarded (no POSITION change, no queue push); decoder keeps running.
REQ-020 Each enabled event SHALL push its direction bit into the queue; push when full SHALL be dropped and set overflow.
REQ-021 Read of EVENT SHALL pop and return {bit31 valid=1, bit0 right}; read when empty SHALL return 0 and not change state.
REQ-022 Simultaneous push and pop when full SHALL both take effect, without overflow.
REQ-023 Write of POSITION SHALL store min(data_in[15:0], LIMIT); same-cycle event's POSITION update SHALL be lost, its queue push kept.
REQ-024 Write of LIMIT below POSITION SHALL clamp POSITION to new LIMIT on the next edge.
REQ-025 Write of CTRL with data_in[13]=1 SHALL clear overflow; other bits written directly.
REQ-026 interrupt SHALL equal registered (irq enable AND (queue non-empty OR overflow)).

Reset
REQ-027 On reset_n=0 at clock edge: synchronizer and q1/delayed q1 = 1, q2 = 0, event = 0; CTRL = 0x10 (step 1, disabled); POSITION = 0; LIMIT = 0xFFFF; queue empty; overflow = 0; ack, data_out, interrupt = 0.
REQ-028 Reset mid-access SHALL suppress the pending ack.

Structure
REQ-029 Register addresses, CTRL bit positions, and default values SHALL live in a shared package rotary_pkg.
REQ-030 The synchronizer plus decoder SHALL be a sub-module rotary_quadrature; the queue stays inline.

Verification
REQ-031 Reset, enable=1, one right detent (00->10->11) -> POSITION 0->1, count 1, interrupt 0 (irq off).
REQ-032 LIMIT=9, POSITION=8, step=3, wrap=0: right -> 9; wrap=1: right -> 0; left from 1 -> 9.
REQ-033 irq enable, 5 right events with FIFO_DEPTH=4 -> count 4, overflow 1, interrupt 1; 4 EVENT reads -> 0x80000001 each, 5th read -> 0, interrupt stays until overflow cleared.
REQ-034 Write POSITION=0x1234 same cycle as decoded left event -> POSITION 0x1234, queue holds one left (read 0x80000000).
REQ-035 POSITION=500, write LIMIT=100 -> POSITION 100 next cycle; write POSITION=200 -> reads 100.
REQ-036 Bounce A toggling 10 times while B held -> at most one event per full detent; enable=0 -> no change.
